spi_shift_engine: RTL and testbench
===================================

// Module: spi_shift_engine
// PURPOSE
//  Datapath half of the SPI peripheral, downstream of the SPI controller FSM. Consumes its
//  shifter_*/counter_* strobes and returns w_done/op_complete. Holds the W-bit shift register,
//  bit/word counters, master SCK divider and slave SCK synchroniser/edge detector.
//  SPI mode 0 only (CPOL=0, CPHA=0), MSB first.
// PARAMETERS
//  W        8   word width in bits (>=2)
//  LEN_W    8   width of len input; word counter is LEN_W+1 bits
//  DIV_W    8   width of clk_div input
// PORTS
//  CLK           in   1      system clock
//  nRST          in   1      asynchronous, active-low reset
//  mode          in   1      1=master, 0=slave
//  clk_div       in   DIV_W  master SCK half-period = clk_div+1 CLK cycles
//  len           in   LEN_W  words per transaction minus 1 (master only)
//  shifter_en    in   1      allow shifting on SCK edges
//  shifter_load  in   1      load sr <= tx_data
//  shifter_rst   in   1      clear sr and captured bit
//  counter_en    in   1      enable SCK generation/detection and bit counting
//  counter_rst   in   1      clear bit_cnt, word_cnt, divider, SCK_OUT
//  tx_data       in   W      word to transmit, sampled when shifter_load=1
//  rx_data       out  W      last fully received word
//  w_done        out  1      1-cycle pulse: word complete
//  op_complete   out  1      master: all len+1 words transferred
//  SCK_IN        in   1      slave serial clock (async)
//  SCK_OUT       out  1      master serial clock
//  SDI           in   1      serial data in (MISO for master, MOSI for slave)
//  SDO           out  1      serial data out = sr[W-1]
// BEHAVIOUR
//  Reset: sr, rx_bit, rx_data, bit_cnt, word_cnt, div_cnt, sync flops, SCK_OUT = 0. Outputs
//   w_done=0, op_complete=0, SDO=0.
//  Edge strobes (internal, 1 CLK each, qualified by counter_en=1):
//   master: div_cnt counts 0..clk_div; at clk_div, SCK_OUT toggles and div_cnt<=0.
//    0->1 toggle = rise, 1->0 toggle = fall.
//   slave: SCK_IN passes through 2 sync flops; rise/fall = edge of synchronised level.
//   counter_en=0: div_cnt<=0, SCK_OUT holds, slave edges discarded (not queued).
//  Shift register (priority shifter_rst > shifter_load > shift):
//   rise & shifter_en: rx_bit <= SDI (master: SDI sampled on the same CLK edge SCK_OUT rises).
//   fall & shifter_en: sr <= {sr[W-2:0], rx_bit}.
//  Counters (priority counter_rst > counter_en):
//   each fall: bit_cnt++. Fall with bit_cnt==W-1: bit_cnt<=0, rx_data <= {sr[W-2:0], rx_bit},
//    word_cnt++.
//   w_done combinational = that final-fall strobe, so controller enters its buffer state the
//    next cycle with rx_data already valid.
//  op_complete = mode & (word_cnt == len+1); combinational from registered word_cnt. Always 0
//   in slave mode.
//  Gap between words: controller drops counter_en one cycle; SCK_OUT already low after the
//   final fall, so no glitch. Next half-period is full length (div_cnt restarted).
//  Slave constraint: SCK_IN high/low each >= 3 CLK; edges during counter_en=0 are lost.
//  Simultaneous rise/fall cannot occur (one toggle per strobe).
//  counter_rst mid-word aborts: bit_cnt/word_cnt 0, no w_done.
//  nRST mid-transfer: all state cleared immediately (async), SCK_OUT=0.
// TESTING
//  1 master W=8 clk_div=1 len=0 tx=0xA5, SDI<-SDO loopback -> 8 SCK pulses of period 4 CLK;
//    SDO 1,0,1,0,0,1,0,1; single w_done; rx_data=0xA5; op_complete=1 next cycle.
//  2 master len=2 tx 0x11,0x22,0x33 reloaded via shifter_load on each w_done -> 3 w_done
//    pulses; SCK low in 1-cycle gaps; op_complete only after 3rd word.
//  3 slave: bench SCK_IN period 8 CLK, SDI=0x3C, tx=0xC3 -> rx_data=0x3C after 8th fall;
//    SDO bits 1,1,0,0,0,0,1,1; op_complete stays 0.
//  4 shifter_rst+shifter_load same cycle -> sr=0. counter_rst after 4 bits -> bit_cnt=0,
//    no w_done.
//  5 clk_div=0 -> SCK_OUT toggles every CLK (CLK/2); word completes 16 CLK after counter_en.
//  6 nRST low mid-word -> SCK_OUT, w_done, rx_data, op_complete all 0 before next CLK edge.

Source files
------------

// File: rtl/spi_shift_engine.sv
// SPI mode-0 datapath: shift register, bit/word counters, master SCK divider and
// slave SCK synchroniser, driven by strobes from the SPI controller FSM.
module spi_shift_engine #(
  parameter int W     = 8,
  parameter int LEN_W = 8,
  parameter int DIV_W = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             mode,
  input  logic [DIV_W-1:0] clk_div,
  input  logic [LEN_W-1:0] len,
  input  logic             shifter_en,
  input  logic             shifter_load,
  input  logic             shifter_rst,
  input  logic             counter_en,
  input  logic             counter_rst,
  input  logic [W-1:0]     tx_data,
  output logic [W-1:0]     rx_data,
  output logic             w_done,
  output logic             op_complete,
  input  logic             SCK_IN,
  output logic             SCK_OUT,
  input  logic             SDI,
  output logic             SDO
);

  localparam int BCW = $clog2(W);
  localparam int WCW = LEN_W + 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(W - 1);

  logic [W-1:0]     sr;
  logic             rx_bit;
  logic [BCW-1:0]   bit_cnt;
  logic [WCW-1:0]   word_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             sck_q;
  logic             sync1, sync2, sync3;

  logic active;
  logic m_tick;
  logic s_rise, s_fall;
  logic rise, fall;
  logic last_fall;

  // counter_rst dominates, so no edge strobe can escape during an abort
  assign active    = counter_en & ~counter_rst;
  assign m_tick    = active & mode & (div_cnt == clk_div);
  assign s_rise    = active & ~mode & sync2 & ~sync3;
  assign s_fall    = active & ~mode & ~sync2 & sync3;
  assign rise      = mode ? (m_tick & ~sck_q) : s_rise;
  assign fall      = mode ? (m_tick & sck_q) : s_fall;
  assign last_fall = fall & (bit_cnt == BIT_LAST);

  assign w_done      = last_fall;
  assign op_complete = mode & (word_cnt == ({1'b0, len} + WCW'(1)));
  assign SCK_OUT     = sck_q;
  assign SDO         = sr[W-1];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      div_cnt <= '0;
      sck_q   <= 1'b0;
    end else if (counter_rst) begin
      div_cnt <= '0;
      sck_q   <= 1'b0;
    end else if (!counter_en || !mode) begin
      div_cnt <= '0;
    end else if (div_cnt == clk_div) begin
      div_cnt <= '0;
      sck_q   <= ~sck_q;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // sync3 tracks continuously so edges seen while counter_en=0 are dropped, not queued
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= SCK_IN;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sr     <= '0;
      rx_bit <= 1'b0;
    end else if (shifter_rst) begin
      sr     <= '0;
      rx_bit <= 1'b0;
    end else if (shifter_load) begin
      sr <= tx_data;
    end else if (shifter_en) begin
      if (rise) rx_bit <= SDI;
      if (fall) sr <= {sr[W-2:0], rx_bit};
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bit_cnt  <= '0;
      word_cnt <= '0;
    end else if (counter_rst) begin
      bit_cnt  <= '0;
      word_cnt <= '0;
    end else if (last_fall) begin
      bit_cnt  <= '0;
      word_cnt <= word_cnt + WCW'(1);
    end else if (fall) begin
      bit_cnt <= bit_cnt + BCW'(1);
    end
  end

  // the word is assembled from sr and rx_bit so it is ready the cycle after w_done
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rx_data <= '0;
    end else if (last_fall) begin
      rx_data <= {sr[W-2:0], rx_bit};
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine; expected words go to a queue that a separate
// monitor drains on each w_done, SDO bits are checked on each observed SCK rise.
module tb_spi_shift_engine;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       mode = 1'b1;
  logic [7:0] clk_div = 8'd1;
  logic [7:0] len = 8'd0;
  logic       shifter_en = 1'b0;
  logic       shifter_load = 1'b0;
  logic       shifter_rst = 1'b0;
  logic       counter_en = 1'b0;
  logic       counter_rst = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic [7:0] rx_data;
  logic       w_done;
  logic       op_complete;
  logic       sck_in = 1'b0;
  logic       sck_out;
  logic       sdi;
  logic       sdo;
  logic       loopback = 1'b0;
  logic       sdi_drv = 1'b0;

  assign sdi = loopback ? sdo : sdi_drv;

  always #5 CLK = ~CLK;

  spi_shift_engine #(.W(8), .LEN_W(8), .DIV_W(8)) dut (
    .CLK(CLK), .nRST(nRST), .mode(mode), .clk_div(clk_div), .len(len),
    .shifter_en(shifter_en), .shifter_load(shifter_load), .shifter_rst(shifter_rst),
    .counter_en(counter_en), .counter_rst(counter_rst), .tx_data(tx_data),
    .rx_data(rx_data), .w_done(w_done), .op_complete(op_complete),
    .SCK_IN(sck_in), .SCK_OUT(sck_out), .SDI(sdi), .SDO(sdo)
  );

  typedef struct packed {
    logic [7:0] rx;
    logic       opc;
  } exp_t;

  exp_t exp_q[$];
  logic sdo_q[$];
  int   total = 0;
  int   bad = 0;
  int   wdone_cnt = 0;
  bit   watch_sdo = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) sdo_q.push_back(b[i]);
  endtask

  task automatic wait_wdone(input int max, output int n);
    n = 0;
    while (n < max) begin
      @(negedge CLK);
      n++;
      if (w_done) return;
    end
    fail("wdone_timeout");
  endtask

  // mode 0 slave byte: SCK_IN period 8 CLK, SDI changes only while SCK_IN is low
  task automatic slave_byte(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      sdi_drv = d[i];
      repeat (2) tick();
      sck_in = 1'b1;
      repeat (4) tick();
      sck_in = 1'b0;
      repeat (2) tick();
    end
  endtask

  initial begin : monitor
    logic prev_sck;
    logic cur_sck;
    exp_t e;
    prev_sck = 1'b0;
    forever begin
      @(negedge CLK);
      cur_sck = mode ? sck_out : sck_in;
      if (watch_sdo && cur_sck && !prev_sck) begin
        if (sdo_q.size() == 0) fail("sdo_unexpected_rise");
        else check("sdo_bit", sdo, sdo_q.pop_front());
      end
      prev_sck = cur_sck;
      if (w_done) begin
        wdone_cnt++;
        if (exp_q.size() == 0) begin
          fail("wdone_unexpected");
        end else begin
          e = exp_q.pop_front();
          @(posedge CLK);
          #1;
          check("rx_data", rx_data, e.rx);
          check("op_complete", op_complete, e.opc);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin : stim
    int n;
    int falls;
    int cyc;
    logic prev;

    #2;
    check("rst_sck_out", sck_out, 0);
    check("rst_w_done", w_done, 0);
    check("rst_op_complete", op_complete, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_sdo", sdo, 0);
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
    tick();

    // 1: master single word 0xA5 with loopback
    mode = 1'b1; loopback = 1'b1; clk_div = 8'd1; len = 8'd0; tx_data = 8'hA5;
    counter_rst = 1'b1; shifter_load = 1'b1;
    tick();
    counter_rst = 1'b0; shifter_load = 1'b0;
    exp_q.push_back('{rx: 8'hA5, opc: 1'b1});
    push_bits(8'hA5);
    watch_sdo = 1'b1;
    shifter_en = 1'b1; counter_en = 1'b1;
    wait_wdone(100, n);
    check("t1_latency", n, 32);
    tick();
    counter_en = 1'b0;
    tick();
    check("t1_wdone_count", wdone_cnt, 1);

    // 2: three words, reloaded in the one-cycle gap after each w_done
    len = 8'd2; tx_data = 8'h11;
    counter_rst = 1'b1; shifter_load = 1'b1;
    tick();
    counter_rst = 1'b0; shifter_load = 1'b0;
    exp_q.push_back('{rx: 8'h11, opc: 1'b0});
    exp_q.push_back('{rx: 8'h22, opc: 1'b0});
    exp_q.push_back('{rx: 8'h33, opc: 1'b1});
    push_bits(8'h11); push_bits(8'h22); push_bits(8'h33);
    counter_en = 1'b1;
    for (int w = 0; w < 3; w++) begin
      wait_wdone(100, n);
      tick();
      if (w < 2) begin
        tx_data = (w == 0) ? 8'h22 : 8'h33;
        shifter_load = 1'b1; counter_en = 1'b0;
        check("t2_gap_sck_low", sck_out, 0);
        tick();
        shifter_load = 1'b0; counter_en = 1'b1;
      end
    end
    counter_en = 1'b0;
    tick();
    check("t2_wdone_count", wdone_cnt, 4);
    watch_sdo = 1'b0;

    // 3: slave receives 0x3C while sending 0xC3
    mode = 1'b0; loopback = 1'b0; sdi_drv = 1'b0; sck_in = 1'b0; tx_data = 8'hC3;
    counter_rst = 1'b1; shifter_load = 1'b1;
    tick();
    counter_rst = 1'b0; shifter_load = 1'b0;
    repeat (3) tick();
    exp_q.push_back('{rx: 8'h3C, opc: 1'b0});
    push_bits(8'hC3);
    watch_sdo = 1'b1;
    counter_en = 1'b1; shifter_en = 1'b1;
    slave_byte(8'h3C);
    repeat (6) tick();
    check("t3_wdone_count", wdone_cnt, 5);
    check("t3_op_complete_slave", op_complete, 0);
    counter_en = 1'b0; watch_sdo = 1'b0;
    tick();

    // 4: shifter_rst beats shifter_load; counter_rst aborts a half-done word
    mode = 1'b1; loopback = 1'b1; clk_div = 8'd1; len = 8'd0; tx_data = 8'hFF;
    shifter_load = 1'b1;
    tick();
    shifter_load = 1'b0;
    check("t4_load_sdo", sdo, 1);
    shifter_rst = 1'b1; shifter_load = 1'b1;
    tick();
    shifter_rst = 1'b0; shifter_load = 1'b0;
    check("t4_rst_over_load", sdo, 0);
    tx_data = 8'hF0; counter_rst = 1'b1; shifter_load = 1'b1;
    tick();
    counter_rst = 1'b0; shifter_load = 1'b0;
    counter_en = 1'b1; shifter_en = 1'b1;
    falls = 0; cyc = 0; prev = 1'b0;
    while (falls < 4 && cyc < 100) begin
      @(negedge CLK);
      cyc++;
      if (prev && !sck_out) falls++;
      prev = sck_out;
    end
    check("t4_four_falls_seen", falls, 4);
    tick();
    tx_data = 8'h5A; counter_rst = 1'b1; shifter_load = 1'b1;
    tick();
    counter_rst = 1'b0; shifter_load = 1'b0;
    check("t4_abort_no_wdone", wdone_cnt, 5);
    exp_q.push_back('{rx: 8'h5A, opc: 1'b1});
    wait_wdone(100, n);
    check("t4_restart_latency", n, 32);
    tick();
    counter_en = 1'b0;
    tick();

    // 5: clk_div=0 gives SCK at CLK/2
    clk_div = 8'd0; tx_data = 8'h96;
    counter_rst = 1'b1; shifter_load = 1'b1;
    tick();
    counter_rst = 1'b0; shifter_load = 1'b0;
    exp_q.push_back('{rx: 8'h96, opc: 1'b1});
    counter_en = 1'b1;
    wait_wdone(100, n);
    check("t5_latency", n, 16);
    tick();
    counter_en = 1'b0;
    tick();

    // 6: asynchronous reset while SCK_OUT is high
    clk_div = 8'd3; tx_data = 8'h3C;
    shifter_load = 1'b1;
    tick();
    shifter_load = 1'b0;
    counter_en = 1'b1;
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (!sck_out && cyc < 50);
    check("t6_sck_high_before", sck_out, 1);
    check("t6_opc_before", op_complete, 1);
    check("t6_rx_before", rx_data, 8'h96);
    #2;
    nRST = 1'b0;
    #1;
    check("t6_sck_out", sck_out, 0);
    check("t6_w_done", w_done, 0);
    check("t6_rx_data", rx_data, 0);
    check("t6_op_complete", op_complete, 0);
    counter_en = 1'b0; shifter_en = 1'b0;
    tick();
    nRST = 1'b1;
    repeat (3) tick();

    check("exp_q_drained", exp_q.size(), 0);
    check("sdo_q_drained", sdo_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
